// File: rtl/bfly_sched.sv
// Radix-2 in-place transform butterfly scheduler: walks stages of a 2^L point
// transform, issues one (A, B, twiddle) descriptor per handshake, caps in-flight work.
module bfly_sched #(
    parameter int pLOGN    = 10,
    parameter int pMAX_OUT = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       cfg_mode,
    input  logic [3:0]       cfg_logn,
    input  logic             abort,
    output logic             o_vld,
    input  logic             o_rdy,
    output logic [pLOGN-1:0] o_addr_a,
    output logic [pLOGN-1:0] o_addr_b,
    output logic [pLOGN-1:0] o_addr_gm,
    output logic [1:0]       o_mode,
    output logic [3:0]       o_stage,
    output logic             o_last,
    input  logic             wb_vld,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [1:0]       dbg_state
);
    localparam int OW = $clog2(pMAX_OUT + 1);
    localparam logic [OW-1:0] OUT_CAP  = OW'(pMAX_OUT);
    localparam logic [3:0]    LOGN_MAX = 4'(pLOGN);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [pLOGN-1:0] k, k_nxt, retired, retired_nxt;
    logic [3:0]       s, s_nxt, logn, logn_nxt;
    logic [1:0]       mode, mode_nxt;
    logic [OW-1:0]    outst, outst_nxt;
    logic             cfg_err_nxt;

    logic             hs, wb_eff, cfg_bad;
    logic [pLOGN-1:0] h_cnt, h_nxt;
    logic [3:0]       lt;
    logic [pLOGN-1:0] t, bi, bj, addr_a, addr_b, addr_gm;
    logic             vld_nxt, last_nxt;

    // Handshake: a descriptor transfers on any cycle with o_vld & o_rdy; while
    // o_vld is high and o_rdy low, every descriptor field holds its value.
    assign hs        = o_vld & o_rdy;
    assign wb_eff    = wb_vld & (outst != '0) & ((state == S_ISSUE) || (state == S_DRAIN));
    assign cfg_bad   = (cfg_logn == 4'd0) || (cfg_logn > LOGN_MAX);
    assign h_cnt     = pLOGN'(1) << (logn - 4'd1);
    assign dbg_state = state;

    always_comb begin
        state_nxt   = state;
        k_nxt       = k;
        s_nxt       = s;
        logn_nxt    = logn;
        mode_nxt    = mode;
        retired_nxt = retired + pLOGN'(wb_eff);
        outst_nxt   = outst + OW'(hs) - OW'(wb_eff);
        cfg_err_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                retired_nxt = '0;
                outst_nxt   = '0;
                if (start) begin
                    if (cfg_bad) begin
                        cfg_err_nxt = 1'b1;
                    end else begin
                        state_nxt = S_ISSUE;
                        logn_nxt  = cfg_logn;
                        mode_nxt  = cfg_mode;
                        k_nxt     = '0;
                        s_nxt     = '0;
                    end
                end
            end
            S_ISSUE: begin
                if (hs) begin
                    if (k == h_cnt - pLOGN'(1)) begin
                        state_nxt = S_DRAIN;
                        k_nxt     = '0;
                    end else begin
                        k_nxt = k + pLOGN'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Stage barrier: every butterfly of this stage must be written back.
                if (retired_nxt == h_cnt) begin
                    retired_nxt = '0;
                    if (s == logn - 4'd1) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ISSUE;
                        s_nxt     = s + 4'd1;
                        k_nxt     = '0;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt   = S_IDLE;
            k_nxt       = '0;
            s_nxt       = '0;
            retired_nxt = '0;
            outst_nxt   = '0;
            cfg_err_nxt = 1'b0;
        end
    end

    // Descriptor for the next cycle; lt = log2 of the butterfly span t.
    always_comb begin
        lt       = mode_nxt[0] ? s_nxt : (logn_nxt - 4'd1 - s_nxt);
        t        = pLOGN'(1) << lt;
        bi       = k_nxt >> lt;
        bj       = k_nxt & (t - pLOGN'(1));
        addr_a   = (bi << (lt + 4'd1)) | bj;
        addr_b   = addr_a + t;
        addr_gm  = (pLOGN'(1) << (logn_nxt - 4'd1 - lt)) + bi;
        h_nxt    = pLOGN'(1) << (logn_nxt - 4'd1);
        vld_nxt  = (state_nxt == S_ISSUE) && (outst_nxt < OUT_CAP);
        last_nxt = vld_nxt && (s_nxt == logn_nxt - 4'd1) && (k_nxt == h_nxt - pLOGN'(1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            k         <= '0;
            s         <= '0;
            logn      <= '0;
            mode      <= '0;
            retired   <= '0;
            outst     <= '0;
            o_vld     <= 1'b0;
            o_addr_a  <= '0;
            o_addr_b  <= '0;
            o_addr_gm <= '0;
            o_mode    <= '0;
            o_stage   <= '0;
            o_last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            s         <= s_nxt;
            logn      <= logn_nxt;
            mode      <= mode_nxt;
            retired   <= retired_nxt;
            outst     <= outst_nxt;
            o_vld     <= vld_nxt;
            o_addr_a  <= vld_nxt ? addr_a : '0;
            o_addr_b  <= vld_nxt ? addr_b : '0;
            o_addr_gm <= vld_nxt ? addr_gm : '0;
            o_mode    <= mode_nxt;
            o_stage   <= s_nxt;
            o_last    <= last_nxt;
            busy      <= (state_nxt == S_ISSUE) || (state_nxt == S_DRAIN);
            done      <= (state_nxt == S_DONE);
            cfg_err   <= cfg_err_nxt;
        end
    end
endmodule

// File: tb/tb_bfly_sched.sv
// Bench for bfly_sched: scoreboard of butterfly descriptors from an arithmetic
// model of the stage/butterfly ordering, with random stalls and echoed retires.
`timescale 1ns/1ps
module tb_bfly_sched;
    localparam int LOGN    = 10;
    localparam int MAX_OUT = 4;
    localparam int W       = 3 * LOGN + 7;

    logic            clk = 1'b0;
    logic            rstn, start, abort, o_vld, o_rdy, o_last, wb_vld, busy, done, cfg_err;
    logic [1:0]      cfg_mode, o_mode, dbg_state;
    logic [3:0]      cfg_logn, o_stage;
    logic [LOGN-1:0] o_addr_a, o_addr_b, o_addr_gm;

    bfly_sched #(.pLOGN(LOGN), .pMAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rstn(rstn), .start(start), .cfg_mode(cfg_mode), .cfg_logn(cfg_logn),
        .abort(abort), .o_vld(o_vld), .o_rdy(o_rdy), .o_addr_a(o_addr_a),
        .o_addr_b(o_addr_b), .o_addr_gm(o_addr_gm), .o_mode(o_mode), .o_stage(o_stage),
        .o_last(o_last), .wb_vld(wb_vld), .busy(busy), .done(done), .cfg_err(cfg_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int         n_checks = 0, n_fail = 0;
    logic [W-1:0] exp_q[$];
    int         hs_cnt = 0, done_cnt = 0, err_cnt = 0, exp_done = 0;
    bit         hs_flag = 1'b0;
    bit         wb_auto = 1'b1, rdy_rand = 1'b0;
    int         rel_req = 0, rel_done = 0, pend = 0;
    logic [1:0] echo_sr = '0;

    int tbl_fwd[36] = '{0,4,1, 1,5,1, 2,6,1, 3,7,1, 0,2,2, 1,3,2, 4,6,3, 5,7,3,
                        0,1,4, 2,3,5, 4,5,6, 6,7,7};
    int tbl_inv[36] = '{0,1,4, 2,3,5, 4,5,6, 6,7,7, 0,2,2, 1,3,2, 4,6,3, 5,7,3,
                        0,4,1, 1,5,1, 2,6,1, 3,7,1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference ordering straight from the butterfly index formulas.
    task automatic push_model(input logic [1:0] mode, input int logn);
        int h;
        h = 2 ** (logn - 1);
        for (int s = 0; s < logn; s++) begin
            for (int k = 0; k < h; k++) begin
                int t, i, j, a, b, gm;
                bit last;
                t    = mode[0] ? 2 ** s : 2 ** (logn - 1 - s);
                i    = k / t;
                j    = k % t;
                a    = i * 2 * t + j;
                b    = a + t;
                gm   = h / t + i;
                last = (s == logn - 1) && (k == h - 1);
                exp_q.push_back({last, 4'(s), mode, LOGN'(gm), LOGN'(b), LOGN'(a)});
            end
        end
    endtask

    task automatic push_tbl(input logic [1:0] mode);
        for (int n = 0; n < 12; n++) begin
            int a, b, gm;
            a  = mode[0] ? tbl_inv[3*n] : tbl_fwd[3*n];
            b  = mode[0] ? tbl_inv[3*n+1] : tbl_fwd[3*n+1];
            gm = mode[0] ? tbl_inv[3*n+2] : tbl_fwd[3*n+2];
            exp_q.push_back({(n == 11), 4'(n / 4), mode, LOGN'(gm), LOGN'(b), LOGN'(a)});
        end
    endtask

    task automatic start_job(input logic [1:0] mode, input int logn);
        step();
        cfg_mode = mode;
        cfg_logn = 4'(logn);
        start    = 1'b1;
        step();
        start    = 1'b0;
        cfg_mode = 2'($urandom_range(0, 3));
        cfg_logn = 4'($urandom_range(0, 15));
        @(negedge clk);
        check("start_busy", busy, 1);
        check("start_vld", o_vld, 1);
        check("start_stage", o_stage, 0);
        if (!rdy_rand && logn >= 3) begin
            repeat (2) begin
                @(negedge clk);
                check("issue_rate", o_vld, 1);
            end
        end
    endtask

    task automatic finish_job(input string name, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, done, 1);
        check("desc_all_issued", exp_q.size(), 0);
        exp_done++;
    endtask

    task automatic run_job(input logic [1:0] mode, input int logn, input bit use_tbl);
        if (use_tbl) push_tbl(mode);
        else push_model(mode, logn);
        start_job(mode, logn);
        finish_job("job_done", 30000);
    endtask

    task automatic wait_stage1();
        int n;
        n = 0;
        while (!(o_vld && o_stage == 4'd1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_stage1", o_stage, 1);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [W-1:0] cur, prev_desc;
        bit           prev_stall, prev_abort;
        prev_stall = 1'b0;
        prev_abort = 1'b0;
        prev_desc  = '0;
        forever begin
            @(negedge clk);
            cur = {o_last, o_stage, o_mode, o_addr_gm, o_addr_b, o_addr_a};
            if (prev_stall && !prev_abort && rstn)
                check("stall_hold", {o_vld, cur}, {1'b1, prev_desc});
            hs_flag = o_vld && o_rdy && rstn;
            if (hs_flag) begin
                hs_cnt++;
                if (exp_q.size() == 0) check("desc_expected", 0, 1);
                else check("desc", cur, exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                check("busy_low_at_done", busy, 0);
            end
            if (cfg_err) err_cnt++;
            prev_stall = o_vld && !o_rdy && rstn;
            prev_abort = abort;
            prev_desc  = cur;
        end
    end

    // Write-back echo (about 3 cycles after each handshake) and o_rdy driver
    initial begin
        wb_vld = 1'b0;
        o_rdy  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) begin
                echo_sr  = '0;
                pend     = 0;
                wb_vld   = 1'b0;
                rel_done = rel_req;
            end else begin
                pend   += int'(echo_sr[1]);
                echo_sr = {echo_sr[0], hs_flag};
                if (pend > 0 && (wb_auto || rel_req != rel_done)) begin
                    wb_vld = 1'b1;
                    pend--;
                    if (!wb_auto) rel_done++;
                end else begin
                    wb_vld = 1'b0;
                end
            end
            o_rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, d0;
        rstn = 1'b0; start = 1'b0; abort = 1'b0; cfg_mode = '0; cfg_logn = '0;
        repeat (3) @(negedge clk);
        check("rst_vld", o_vld, 0);
        check("rst_addr_a", o_addr_a, 0);
        check("rst_addr_b", o_addr_b, 0);
        check("rst_addr_gm", o_addr_gm, 0);
        check("rst_mode", o_mode, 0);
        check("rst_stage", o_stage, 0);
        check("rst_last", o_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        step();
        rstn = 1'b1;

        run_job(2'b10, 3, 1'b1);
        run_job(2'b11, 3, 1'b1);
        rdy_rand = 1'b1;
        run_job(2'b00, 10, 1'b0);
        run_job(2'b01, 1, 1'b0);
        repeat (3) run_job(2'($urandom_range(0, 3)), $urandom_range(1, 10), 1'b0);
        rdy_rand = 1'b0;

        // In-flight cap with write-backs withheld
        wb_auto = 1'b0;
        push_model(2'b00, 4);
        hs0 = hs_cnt;
        start_job(2'b00, 4);
        repeat (12) @(negedge clk);
        check("cap_issue_count", hs_cnt - hs0, MAX_OUT);
        check("cap_vld_low", o_vld, 0);
        step();
        rel_req++;
        @(negedge clk);
        @(negedge clk);
        check("cap_vld_in_wb_cycle", o_vld, 0);
        @(negedge clk);
        check("cap_reraise", o_vld, 1);
        repeat (6) @(negedge clk);
        check("cap_one_more", hs_cnt - hs0, MAX_OUT + 1);
        check("cap_vld_low_again", o_vld, 0);
        wb_auto = 1'b1;
        finish_job("cap_job_done", 500);

        // Stage barrier: hold the last write-back of stage 0 for 20 cycles
        wb_auto = 1'b0;
        push_model(2'b01, 3);
        hs0 = hs_cnt;
        start_job(2'b01, 3);
        for (int n = 0; n < 20 && hs_cnt - hs0 < 4; n++) @(negedge clk);
        check("stage0_issued", hs_cnt - hs0, 4);
        repeat (5) @(negedge clk);
        step();
        rel_req += 3;
        repeat (6) @(negedge clk);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("barrier_hold", o_vld, 0);
        end
        step();
        rel_req++;
        @(negedge clk);
        @(negedge clk);
        check("barrier_release_cycle", o_vld, 0);
        @(negedge clk);
        check("barrier_next_vld", o_vld, 1);
        check("barrier_next_stage", o_stage, 1);
        wb_auto = 1'b1;
        finish_job("barrier_job_done", 500);

        // Illegal sizes
        foreach (tbl_fwd[n]) begin
            if (n < 2) begin
                step();
                cfg_logn = (n == 0) ? 4'd0 : 4'd11;
                start    = 1'b1;
                step();
                start    = 1'b0;
                @(negedge clk);
                check("cfg_err_pulse", cfg_err, 1);
                check("cfg_err_busy", busy, 0);
                check("cfg_err_vld", o_vld, 0);
                @(negedge clk);
                check("cfg_err_one_cycle", cfg_err, 0);
                check("cfg_err_busy_after", busy, 0);
            end
        end

        // Abort mid stage 1
        push_model(2'b10, 4);
        d0 = done_cnt;
        start_job(2'b10, 4);
        wait_stage1();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check("abort_vld", o_vld, 0);
        check("abort_busy", busy, 0);
        check("abort_stage", o_stage, 0);
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        exp_q.delete();
        run_job(2'b10, 4, 1'b0);

        // Reset mid stage 1
        push_model(2'b00, 4);
        d0 = done_cnt;
        start_job(2'b00, 4);
        wait_stage1();
        step();
        rstn = 1'b0;
        @(negedge clk);
        check("rst_mid_vld", o_vld, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_stage", o_stage, 0);
        check("rst_mid_addr_a", o_addr_a, 0);
        repeat (2) step();
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        exp_q.delete();
        run_job(2'b00, 4, 1'b0);

        repeat (10) @(negedge clk);
        check("done_total", done_cnt, exp_done);
        check("cfg_err_total", err_cnt, 2);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
